// File: rtl/trigger_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_capture_if
//  Purpose  : Bundles the sample stream, trigger controls and RAM write
//             port of the trigger capture controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface trigger_capture_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic [DATA_W-1:0] trig_level;
  logic              trig_falling;
  logic              auto_mode;
  logic              rearm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] trig_addr;
  logic              capture_done;
  logic              armed;
  logic              auto_fired;

  // Source side: ADC channel and control registers
  modport master (
    output sample_in, sample_valid, trig_level, trig_falling, auto_mode, rearm,
    input  wr_en, wr_addr, wr_data, trig_addr, capture_done, armed, auto_fired
  );

  // Capture controller side
  modport slave (
    input  sample_in, sample_valid, trig_level, trig_falling, auto_mode, rearm,
    output wr_en, wr_addr, wr_data, trig_addr, capture_done, armed, auto_fired
  );
endinterface
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_capture
//  Purpose  : Circular-buffer capture controller. Keeps PRE_DEPTH samples of
//             history, waits for a level crossing (or auto timeout), records
//             the post-trigger window and freezes the buffer until re-armed.
//  Revision : 1.0 - initial release
// ============================================================================
module trigger_capture #(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 10,
  parameter int PRE_DEPTH    = 320,
  parameter int AUTO_TIMEOUT = 5000000
) (
  input wire logic         clk,
  input wire logic         reset_n,
  trigger_capture_if.slave bus
);

  localparam int TMO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  c_TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] c_PRE_DEPTH = ADDR_W'(PRE_DEPTH);
  // Post window includes the trigger sample itself
  localparam logic [ADDR_W-1:0] c_POST_LEN  = ADDR_W'((1 << ADDR_W) - PRE_DEPTH);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0] r_pre_cnt, w_pre_nxt;
  logic [ADDR_W-1:0] r_post_cnt, w_post_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic              r_force, w_force_nxt;
  logic [DATA_W-1:0] r_prev, w_prev_nxt;

  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
  logic [ADDR_W-1:0] r_trig_addr, w_trig_addr_nxt;
  logic              r_done, w_done_nxt;
  logic              r_armed, w_armed_nxt;
  logic              r_auto_fired, w_auto_fired_nxt;

  logic w_valid;
  logic w_write;
  logic w_cross;
  logic w_forced;

  assign w_valid  = bus.sample_valid;
  assign w_write  = w_valid && (r_state != S_DONE);
  // Unsigned level crossing against the previously written sample
  assign w_cross  = bus.trig_falling
                  ? ((r_prev > bus.trig_level) && (bus.sample_in <= bus.trig_level))
                  : ((r_prev < bus.trig_level) && (bus.sample_in >= bus.trig_level));
  // Force only honoured while auto mode is still enabled
  assign w_forced = r_force && bus.auto_mode;

  // Next-state, write-path and registered-output computation
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_pre_nxt        = r_pre_cnt;
    w_post_nxt       = r_post_cnt;
    w_tmo_nxt        = '0;
    w_force_nxt      = 1'b0;
    w_prev_nxt       = r_prev;
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_trig_addr_nxt  = r_trig_addr;
    w_auto_fired_nxt = r_auto_fired;

    if (w_write) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_addr_nxt = r_ptr;
      w_wr_data_nxt = bus.sample_in;
      w_ptr_nxt     = r_ptr + ADDR_W'(1);
      w_prev_nxt    = bus.sample_in;
    end

    case (r_state)
      S_FILL: begin
        if (w_valid) begin
          w_pre_nxt = r_pre_cnt + ADDR_W'(1);
          if (w_pre_nxt == c_PRE_DEPTH) begin
            w_state_nxt = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        // Timeout counter saturates at its last value once force is set
        if (bus.auto_mode) begin
          if (r_tmo == c_TMO_LAST) begin
            w_tmo_nxt   = r_tmo;
            w_force_nxt = 1'b1;
          end else begin
            w_tmo_nxt   = r_tmo + TMO_W'(1);
          end
        end
        if (w_valid && (w_cross || w_forced)) begin
          w_trig_addr_nxt  = r_ptr;
          w_post_nxt       = ADDR_W'(1);
          w_auto_fired_nxt = !w_cross;
          w_state_nxt      = (c_POST_LEN == ADDR_W'(1)) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (w_valid) begin
          w_post_nxt = r_post_cnt + ADDR_W'(1);
          if (w_post_nxt == c_POST_LEN) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.rearm) begin
          w_state_nxt      = S_FILL;
          w_pre_nxt        = '0;
          w_auto_fired_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase

    w_done_nxt  = (w_state_nxt == S_DONE);
    w_armed_nxt = (w_state_nxt == S_ARMED);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr        <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_tmo        <= '0;
      r_force      <= 1'b0;
      r_prev       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_trig_addr  <= '0;
      r_done       <= 1'b0;
      r_armed      <= 1'b0;
      r_auto_fired <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_pre_cnt    <= w_pre_nxt;
      r_post_cnt   <= w_post_nxt;
      r_tmo        <= w_tmo_nxt;
      r_force      <= w_force_nxt;
      r_prev       <= w_prev_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_trig_addr  <= w_trig_addr_nxt;
      r_done       <= w_done_nxt;
      r_armed      <= w_armed_nxt;
      r_auto_fired <= w_auto_fired_nxt;
    end
  end

  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.trig_addr    = r_trig_addr;
  assign bus.capture_done = r_done;
  assign bus.armed        = r_armed;
  assign bus.auto_fired   = r_auto_fired;

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trigger_capture
//  Purpose  : Randomised and directed bench for trigger_capture with a
//             queue-based scoreboard for RAM writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

  localparam int DATA_W   = 12;
  localparam int ADDR_W   = 4;
  localparam int PRE      = 4;
  localparam int TMO      = 20;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int POST_LEN = DEPTH - PRE;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  trigger_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  trigger_capture #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRE_DEPTH(PRE), .AUTO_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a capture is described by how many samples were
  // written, whether a trigger happened, and how many post samples followed.
  int m_ptr, m_nw, m_post, m_armcyc, m_trig_addr, m_prev;
  bit m_trig, m_done, m_auto_fired, m_wr;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit model_armed();
    return !m_done && !m_trig && (m_nw >= PRE);
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_nw = 0; m_post = 0; m_armcyc = 0; m_trig_addr = 0; m_prev = 0;
    m_trig = 0; m_done = 0; m_auto_fired = 0; m_wr = 0;
  endfunction

  function automatic void model_step(bit v, int s, bit ra);
    bit armed, forced, hit;
    int lvl;
    m_wr = 0;
    if (m_done) begin
      if (ra) begin
        m_done = 0; m_nw = 0; m_trig = 0; m_armcyc = 0; m_auto_fired = 0;
      end
      return;
    end
    armed  = model_armed();
    forced = bus.auto_mode && (m_armcyc >= TMO);
    lvl    = int'(bus.trig_level);
    if (v) begin
      m_wr = 1;
      exp_q.push_back('{addr: m_ptr, data: s});
      if (armed) begin
        hit = bus.trig_falling ? (m_prev > lvl && s <= lvl) : (m_prev < lvl && s >= lvl);
        if (hit || forced) begin
          m_trig = 1; m_trig_addr = m_ptr; m_auto_fired = !hit; m_post = 1;
          if (m_post == POST_LEN) m_done = 1;
        end
      end else if (m_trig) begin
        m_post++;
        if (m_post == POST_LEN) m_done = 1;
      end
      m_nw++;
      m_prev = s;
      m_ptr  = (m_ptr + 1) % DEPTH;
    end
    if (armed) m_armcyc = bus.auto_mode ? m_armcyc + 1 : 0;
  endfunction

  // Scoreboard monitor: every presented write must match the oldest expected one
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        check("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
    end
  end

  task automatic tick(bit v, logic [DATA_W-1:0] s, bit ra);
    bus.sample_valid = v;
    bus.sample_in    = s;
    bus.rearm        = ra;
    model_step(v, int'(s), ra);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    bus.rearm        = 1'b0;
    check("wr_en",      32'(bus.wr_en),        32'(m_wr));
    check("armed",      32'(bus.armed),        32'(model_armed()));
    check("done",       32'(bus.capture_done), 32'(m_done));
    check("auto_fired", 32'(bus.auto_fired),   32'(m_auto_fired));
    check("trig_addr",  32'(bus.trig_addr),    32'(m_trig_addr));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.sample_valid = 1'b0;
    bus.rearm = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_wr_en",  32'(bus.wr_en), 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    check("rst_trig_addr", 32'(bus.trig_addr), 0);
    check("rst_done",   32'(bus.capture_done), 0);
    check("rst_armed",  32'(bus.armed), 0);
    check("rst_auto",   32'(bus.auto_fired), 0);
    reset_n = 1'b1;
  endtask

  // Feed samples until the DUT freezes; fixed < 0 means random sample values
  task automatic run_to_done(int fixed, int bound);
    for (int n = 0; n < bound && !m_done; n++) begin
      tick(1'b1, (fixed < 0) ? DATA_W'($urandom_range(0, 4095)) : DATA_W'(fixed), 1'b0);
    end
    check("done_reached", 32'(bus.capture_done), 1);
  endtask

  initial begin
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.trig_level = '0;
    bus.trig_falling = 1'b0; bus.auto_mode = 1'b0; bus.rearm = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Rising trigger at address 6, window wraps to address 1
    bus.trig_level = 12'd250; bus.trig_falling = 1'b0; bus.auto_mode = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, 12'd0, 1'b0);
    tick(1'b1, 12'd300, 1'b0);
    check("t1_trig_addr", 32'(bus.trig_addr), 6);
    run_to_done(-1, 40);
    check("t1_last_addr", 32'(bus.wr_addr), 1);

    // Frozen buffer ignores strobes; rearm with a strobe writes nothing
    for (int i = 0; i < 5; i++) tick(1'b1, DATA_W'($urandom_range(0, 4095)), 1'b0);
    tick(1'b1, 12'd77, 1'b1);
    check("t4_done_clr", 32'(bus.capture_done), 0);
    tick(1'b1, 12'd5, 1'b0);
    check("t4_ptr_kept", 32'(bus.wr_addr), 2);
    run_to_done(-1, 200);

    // Falling trigger at address 5
    do_reset();
    bus.trig_level = 12'd2048; bus.trig_falling = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1, 12'd4095, 1'b0);
    tick(1'b1, 12'd2048, 1'b0);
    check("t2_trig_addr", 32'(bus.trig_addr), 5);
    run_to_done(-1, 40);
    // Preceding sample equal to level must not trigger
    tick(1'b0, 12'd0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 12'd2048, 1'b0);
    tick(1'b1, 12'd100, 1'b0);
    check("t2_eq_no_trig", 32'(bus.armed), 1);
    run_to_done(-1, 200);

    // Auto-trigger on a flat signal
    tick(1'b0, 12'd0, 1'b1);
    bus.trig_level = 12'd2000; bus.trig_falling = 1'b0; bus.auto_mode = 1'b1;
    run_to_done(1000, 100);
    check("t3_auto_fired", 32'(bus.auto_fired), 1);
    tick(1'b0, 12'd0, 1'b1);
    bus.auto_mode = 1'b0;
    for (int i = 0; i < 80; i++) tick(1'($urandom_range(0, 1)), 12'd1000, 1'b0);
    check("t3_still_armed", 32'(bus.armed), 1);
    run_to_done(3000, 40);
    check("t3_real_trig", 32'(bus.auto_fired), 0);

    // Reset in the middle of the post window
    tick(1'b0, 12'd0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 12'd0, 1'b0);
    tick(1'b1, 12'd3000, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 12'd9, 1'b0);
    do_reset();
    tick(1'b1, 12'd123, 1'b0);
    check("t5_addr0", 32'(bus.wr_addr), 0);

    // Randomised traffic, including back-to-back strobes and stray rearms
    for (int i = 0; i < 3000; i++) begin
      bit ra;
      ra = ($urandom_range(0, 19) == 0);
      if (ra && m_done) begin
        bus.trig_level   = DATA_W'($urandom_range(0, 4095));
        bus.trig_falling = 1'($urandom_range(0, 1));
        bus.auto_mode    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      tick((i % 500 < 100) ? 1'b1 : 1'($urandom_range(0, 3) != 0),
           DATA_W'($urandom_range(0, 4095)), ra);
    end

    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
